multicycle_decoder: RTL and testbench

- Multicycle successor to the single-cycle main decoder.
- Decodes the same Op/Funct instruction classes (data-processing register/immediate, LDR, STR, B) through a Moore state machine.
- Handshakes with a variable-latency memory via MemReq/MemReady and counts retired instructions.
- Flags illegal opcodes and memory timeouts with a sticky fault.
- Sits between the instruction register and the multicycle datapath; condition checking and ALU decoding stay external.

---
 rtl/multicycle_decoder_if.sv | 54 +++++
 rtl/multicycle_decoder.sv | 211 +++++++++++++++++++++
 tb/tb_multicycle_decoder.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_decoder_if.sv
//------------------------------------------------------------------------------
// Module   : multicycle_decoder_if
// Purpose  : Bundles the instruction fields, the memory handshake and every
//            datapath control line exchanged by multicycle_decoder.
// Modports : master - the decoder (drives controls, samples Op/Funct/MemReady)
//            slave  - instruction register / memory / datapath side
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface multicycle_decoder_if #(
  parameter int CNT_W = 32
);
  // Instruction fields and memory status
  logic [1:0]       Op;
  logic [5:0]       Funct;
  logic             MemReady;
  // Memory handshake
  logic             MemReq;
  logic             MemW;
  logic             AdrSrc;
  // Datapath controls
  logic             IRWrite;
  logic             PCWrite;
  logic             Branch;
  logic             RegW;
  logic [1:0]       ResultSrc;
  logic             ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic             ALUOp;
  logic [1:0]       ImmSrc;
  logic [1:0]       RegSrc;
  // Status
  logic             Retire;
  logic [CNT_W-1:0] InstrCount;
  logic             Fault;
  logic [1:0]       FaultCode;

  modport master (
    input  Op, Funct, MemReady,
    output MemReq, MemW, AdrSrc, IRWrite, PCWrite, Branch, RegW,
           ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, RegSrc,
           Retire, InstrCount, Fault, FaultCode
  );

  modport slave (
    output Op, Funct, MemReady,
    input  MemReq, MemW, AdrSrc, IRWrite, PCWrite, Branch, RegW,
           ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, RegSrc,
           Retire, InstrCount, Fault, FaultCode
  );
endinterface

`default_nettype wire

// File: rtl/multicycle_decoder.sv
//------------------------------------------------------------------------------
// Module   : multicycle_decoder
// Purpose  : Moore-style main decoder for the multicycle datapath. Walks each
//            instruction (DP reg/imm, LDR, STR, B) through its control states,
//            handshakes with a variable-latency memory, counts retired
//            instructions and latches a sticky fault on an illegal opcode or
//            a memory timeout.
// Ports    : clk   - system clock, rising edge
//            reset - asynchronous active-high reset
//            bus   - multicycle_decoder_if.master (fields, handshake, controls,
//                    Retire/InstrCount, Fault/FaultCode)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module multicycle_decoder #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32,
  parameter int TO_W        = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  multicycle_decoder_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_FAULT    = 4'd10
  } state_t;

  localparam bit            c_to_en   = (MEM_TIMEOUT > 0);
  // Counter value seen in the last wait cycle that is still tolerated.
  localparam logic [TO_W-1:0] c_to_last = (MEM_TIMEOUT > 0) ? TO_W'(MEM_TIMEOUT - 1) : '0;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic [1:0]       fault_code_q, fault_code_d;

  // Ungated control decode
  logic       mem_req, mem_w, adr_src, ir_write, pc_write, branch, reg_w;
  logic       alu_src_a, alu_op, retire;
  logic [1:0] result_src, alu_src_b;
  logic       mem_wait, mem_timeout;

  // Funct[4:1] carry no control meaning for this decoder.
  logic w_unused_funct;
  assign w_unused_funct = ^bus.Funct[4:1];

  //--------------------------------------------------------------------------
  // Control outputs: function of state plus MemReady only
  //--------------------------------------------------------------------------
  always_comb begin
    mem_req    = 1'b0;
    mem_w      = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    branch     = 1'b0;
    reg_w      = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 1'b0;
    retire     = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = bus.MemReady;
        pc_write   = bus.MemReady;
      end
      S_DECODE: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
      end
      S_MEMADR: begin
        alu_src_b  = 2'b01;
      end
      S_MEMREAD: begin
        mem_req    = 1'b1;
        adr_src    = 1'b1;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_w      = 1'b1;
        retire     = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req    = 1'b1;
        mem_w      = 1'b1;
        adr_src    = 1'b1;
        retire     = bus.MemReady;
      end
      S_EXECUTER: begin
        alu_op     = 1'b1;
      end
      S_EXECUTEI: begin
        alu_src_b  = 2'b01;
        alu_op     = 1'b1;
      end
      S_ALUWB: begin
        reg_w      = 1'b1;
        retire     = 1'b1;
      end
      S_BRANCH: begin
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        branch     = 1'b1;
        retire     = 1'b1;
      end
      default: ;
    endcase
  end

  // Enables drop combinationally while reset is high so that a reset in the
  // middle of a transfer cannot leave a stray write strobe for the cycle.
  assign bus.MemReq     = mem_req  & ~reset;
  assign bus.MemW       = mem_w    & ~reset;
  assign bus.IRWrite    = ir_write & ~reset;
  assign bus.PCWrite    = pc_write & ~reset;
  assign bus.RegW       = reg_w    & ~reset;
  assign bus.Branch     = branch   & ~reset;
  assign bus.AdrSrc     = adr_src;
  assign bus.ResultSrc  = result_src;
  assign bus.ALUSrcA    = alu_src_a;
  assign bus.ALUSrcB    = alu_src_b;
  assign bus.ALUOp      = alu_op;
  assign bus.Retire     = retire;
  assign bus.ImmSrc     = bus.Op;
  assign bus.RegSrc     = {bus.Op == 2'b01, bus.Op == 2'b10};
  assign bus.InstrCount = count_q;
  assign bus.Fault      = (state_q == S_FAULT);
  assign bus.FaultCode  = fault_code_q;

  //--------------------------------------------------------------------------
  // Next state, retire counter and timeout counter
  //--------------------------------------------------------------------------
  assign mem_wait    = mem_req & ~bus.MemReady;
  // Completion in the final tolerated cycle wins because mem_wait is low then.
  assign mem_timeout = c_to_en & mem_wait & (to_q == c_to_last);

  always_comb begin
    state_d      = state_q;
    fault_code_d = fault_code_q;
    count_d      = retire ? count_q + CNT_W'(1) : count_q;
    // Outside a wait cycle the counter sits at zero, which covers both
    // clear-on-entry and clear-on-completion.
    to_d         = mem_wait ? to_q + TO_W'(1) : '0;

    case (state_q)
      S_FETCH:    if (bus.MemReady) state_d = S_DECODE;
      S_DECODE: begin
        case (bus.Op)
          2'b00:   state_d = bus.Funct[5] ? S_EXECUTEI : S_EXECUTER;
          2'b01:   state_d = S_MEMADR;
          2'b10:   state_d = S_BRANCH;
          default: begin
            state_d      = S_FAULT;
            fault_code_d = 2'b01;
          end
        endcase
      end
      S_MEMADR:   state_d = bus.Funct[0] ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (bus.MemReady) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (bus.MemReady) state_d = S_FETCH;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_FAULT:    state_d = S_FAULT;
      default:    state_d = S_FAULT;
    endcase

    if (mem_timeout) begin
      state_d      = S_FAULT;
      fault_code_d = 2'b10;
      to_d         = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_FETCH;
      count_q      <= '0;
      to_q         <= '0;
      fault_code_q <= 2'b00;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      to_q         <= to_d;
      fault_code_q <= fault_code_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_decoder.sv
//------------------------------------------------------------------------------
// Module   : tb_multicycle_decoder
// Purpose  : Self-checking bench for multicycle_decoder. An instruction-level
//            model expands each instruction class and its wait states into the
//            expected per-cycle control pattern.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_multicycle_decoder;

  localparam int TIMEOUT = 4;
  localparam int CNT     = 4;

  typedef enum int {
    P_FETCH, P_DECODE, P_MEMADR, P_MEMREAD, P_MEMWB, P_MEMWRITE,
    P_EXECR, P_EXECI, P_ALUWB, P_BRANCH
  } phase_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  multicycle_decoder_if #(.CNT_W(CNT)) bus ();

  multicycle_decoder #(
    .MEM_TIMEOUT(TIMEOUT),
    .CNT_W      (CNT),
    .TO_W       (8)
  ) dut (
    .clk  (clk),
    .reset(rst),
    .bus  (bus)
  );

  int         total = 0;
  int         bad   = 0;
  int         model_cnt = 0;
  bit         model_fault = 1'b0;
  logic [1:0] model_code = 2'b00;
  logic [1:0] cur_op = 2'b00;
  bit         in_rst = 1'b1;

  initial begin
    #400000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // Expected control word for one cycle of an instruction phase.
  function automatic logic [20:0] expect_vec(phase_t ph, logic rdy, logic [1:0] op,
                                             bit r, bit flt, logic [1:0] code);
    logic req, w, adr, irw, pcw, br, rw, a, aop, ret;
    logic [1:0] res, b;
    {req, w, adr, irw, pcw, br, rw, a, aop, ret} = '0;
    res = 2'b00;
    b   = 2'b00;
    if (!flt) begin
      case (ph)
        P_FETCH:    begin req = 1; a = 1; b = 2; res = 2; irw = rdy; pcw = rdy; end
        P_DECODE:   begin a = 1; b = 2; res = 2; end
        P_MEMADR:   begin b = 1; end
        P_MEMREAD:  begin req = 1; adr = 1; end
        P_MEMWB:    begin res = 1; rw = 1; ret = 1; end
        P_MEMWRITE: begin req = 1; w = 1; adr = 1; ret = rdy; end
        P_EXECR:    begin aop = 1; end
        P_EXECI:    begin b = 1; aop = 1; end
        P_ALUWB:    begin rw = 1; ret = 1; end
        P_BRANCH:   begin b = 1; res = 2; br = 1; ret = 1; end
        default: ;
      endcase
    end
    if (r) {req, w, irw, pcw, rw, br} = '0;
    return {req, w, adr, irw, pcw, br, rw, res, a, b, aop, ret,
            op, (op == 2'b01), (op == 2'b10), flt, (flt ? code : 2'b00)};
  endfunction

  function automatic logic [20:0] observed();
    return {bus.MemReq, bus.MemW, bus.AdrSrc, bus.IRWrite, bus.PCWrite, bus.Branch,
            bus.RegW, bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.Retire,
            bus.ImmSrc, bus.RegSrc, bus.Fault, bus.FaultCode};
  endfunction

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_now(input string tag, input phase_t ph, input logic rdy);
    logic [20:0] e;
    e = expect_vec(ph, rdy, cur_op, in_rst, model_fault, model_code);
    cmp(tag, {11'b0, observed()}, {11'b0, e});
    cmp({tag, "_cnt"}, {28'b0, bus.InstrCount}, model_cnt % (1 << CNT));
    if (e[7]) model_cnt++;
  endtask

  task automatic step(input string tag, input phase_t ph, input logic rdy);
    @(negedge clk);
    bus.MemReady = rdy;
    #1;
    check_now(tag, ph, rdy);
  endtask

  // One memory transfer with w wait cycles; stops at the timeout limit.
  task automatic mem_phase(input string tag, input phase_t ph, input int w, output bit ok);
    ok = 1'b1;
    for (int k = 0; k <= w; k++) begin
      step(tag, ph, (k == w));
      if (k != w && k + 1 == TIMEOUT) begin
        model_fault = 1'b1;
        model_code  = 2'b10;
        ok = 1'b0;
        return;
      end
    end
  endtask

  task automatic run_instr(input logic [1:0] op, input logic [5:0] fn, input int wf, input int wm);
    bit ok;
    bus.Op    = op;
    bus.Funct = fn;
    cur_op    = op;
    mem_phase("fetch", P_FETCH, wf, ok);
    if (!ok) return;
    step("decode", P_DECODE, 1'($urandom));
    case (op)
      2'b00: begin
        step("exec", fn[5] ? P_EXECI : P_EXECR, 1'($urandom));
        step("aluwb", P_ALUWB, 1'($urandom));
      end
      2'b01: begin
        step("memadr", P_MEMADR, 1'($urandom));
        if (fn[0]) begin
          mem_phase("memread", P_MEMREAD, wm, ok);
          if (ok) step("memwb", P_MEMWB, 1'($urandom));
        end else begin
          mem_phase("memwrite", P_MEMWRITE, wm, ok);
        end
      end
      2'b10: step("branch", P_BRANCH, 1'($urandom));
      default: begin
        model_fault = 1'b1;
        model_code  = 2'b01;
      end
    endcase
  endtask

  task automatic fault_hold(input int n);
    repeat (n) step("fault", P_FETCH, 1'($urandom));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst         = 1'b1;
    in_rst      = 1'b1;
    model_cnt   = 0;
    model_fault = 1'b0;
    model_code  = 2'b00;
    bus.MemReady = 1'b1;
    #1;
    check_now("reset", P_FETCH, 1'b1);
    @(posedge clk);
    #2;
    rst    = 1'b0;
    in_rst = 1'b0;
  endtask

  initial begin
    bit ok;
    bus.Op       = 2'b00;
    bus.Funct    = 6'b0;
    bus.MemReady = 1'b0;

    // Reset state, then a zero-wait DP register instruction
    do_reset();
    run_instr(2'b00, 6'b000000, 0, 0);
    @(posedge clk); #1;
    cmp("dp_count", {28'b0, bus.InstrCount}, 32'd1);

    // LDR with two wait cycles in MEMREAD
    run_instr(2'b01, 6'b000001, 0, 2);
    // STR and DP immediate with waits
    run_instr(2'b01, 6'b000000, 1, 3);
    run_instr(2'b00, 6'b100000, 2, 0);

    // Fetch never ready: timeout after TIMEOUT request cycles
    do_reset();
    run_instr(2'b00, 6'b000000, TIMEOUT, 0);
    fault_hold(3);
    // Ready on the last tolerated cycle: completion wins
    do_reset();
    run_instr(2'b00, 6'b000000, TIMEOUT - 1, 0);

    // Illegal opcode
    run_instr(2'b11, 6'b000000, 0, 0);
    fault_hold(20);
    do_reset();
    run_instr(2'b10, 6'b000000, 0, 0);

    // Reset asserted in the middle of a stalled store
    bus.Op = 2'b01; bus.Funct = 6'b000000; cur_op = 2'b01;
    mem_phase("fetch", P_FETCH, 0, ok);
    step("decode", P_DECODE, 1'b0);
    step("memadr", P_MEMADR, 1'b0);
    step("memwrite", P_MEMWRITE, 1'b0);
    #2;
    rst = 1'b1; in_rst = 1'b1; model_cnt = 0;
    #1;
    check_now("rst_memwrite", P_FETCH, 1'b0);
    @(posedge clk); #2;
    rst = 1'b0; in_rst = 1'b0;

    // Counter wrap with 17 back-to-back branches
    do_reset();
    for (int i = 1; i <= 17; i++) begin
      run_instr(2'b10, 6'($urandom), 0, 0);
      @(posedge clk); #1;
      if (i == 15) cmp("wrap15", {28'b0, bus.InstrCount}, 32'd15);
      if (i == 16) cmp("wrap0",  {28'b0, bus.InstrCount}, 32'd0);
      if (i == 17) cmp("wrap1",  {28'b0, bus.InstrCount}, 32'd1);
    end

    // Randomized instruction stream
    for (int n = 0; n < 60; n++) begin
      logic [1:0] op;
      int wf, wm;
      op = ($urandom % 10 == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      wf = ($urandom % 8 == 0) ? TIMEOUT : int'($urandom_range(0, 3));
      wm = ($urandom % 8 == 0) ? TIMEOUT : int'($urandom_range(0, 3));
      run_instr(op, 6'($urandom), wf, wm);
      if (model_fault) begin
        fault_hold(3);
        do_reset();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
